// File: rtl/display_hdmi_timing_gen.sv
// -----------------------------------------------------------------------------
// display_hdmi_timing_gen
//
// Purpose:
//   Generates 1-pixel/clock HDMI raster timing (Hs/Vs/De) and pulls RGB888
//   pixels from a show-ahead (FWFT) display FIFO during active video. The
//   registered outputs feed the RGB-to-YUV stage directly. A FIFO that runs
//   dry while a pixel is needed is flagged on a sticky underflow status bit,
//   and the raster keeps running; it never stalls.
//
//   Line order is active, front porch, sync, back porch. Frame order is the
//   same, in lines. Once running, a frame always completes: a dropped
//   iEnable is only honoured on the last clock of a frame.
//
// Configuration:
//   DISPLAY_HDMI_COLORBAR_EN - when defined, iPatternSel (sampled on the first
//   clock of each frame and held for that frame) replaces FIFO data with
//   eight vertical colour bars. Pattern frames never pop the FIFO and never
//   flag underflow. When undefined, iPatternSel is ignored and no bar logic
//   exists.
//
// Ports:
//   iHdmiClk     in   pixel clock
//   iRst_n       in   synchronous active-low reset
//   iEnable      in   raster run request
//   iPatternSel  in   1 = colour bars instead of FIFO data (macro builds only)
//   iClrStatus   in   clears oUnderflow (a simultaneous set wins)
//   iv24Pix      in   FIFO head {R,G,B}, valid when iPixEmpty is low
//   iPixEmpty    in   FIFO empty
//   oPixRd       out  FIFO pop, combinational, in the cycle the head is used
//   ov8Red/ov8Green/ov8Blue out  registered pixel, 0 during blanking
//   oRgbVd       out  data enable, active high
//   oRgbVs       out  vsync, active high
//   oRgbHs       out  hsync, active high
//   oFrameStart  out  one-clock pulse alongside the first active pixel
//   oUnderflow   out  sticky FIFO underflow flag
//
//   All registered outputs lag the counter state by one clock and are
//   mutually aligned.
// -----------------------------------------------------------------------------
module display_hdmi_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int CNT_W    = 12
) (
    input  logic        iHdmiClk,
    input  logic        iRst_n,
    input  logic        iEnable,
    input  logic        iPatternSel,
    input  logic        iClrStatus,
    input  logic [23:0] iv24Pix,
    input  logic        iPixEmpty,
    output logic        oPixRd,
    output logic [7:0]  ov8Red,
    output logic [7:0]  ov8Green,
    output logic [7:0]  ov8Blue,
    output logic        oRgbVd,
    output logic        oRgbVs,
    output logic        oRgbHs,
    output logic        oFrameStart,
    output logic        oUnderflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sized boundary constants so every counter compare is width-matched.
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   v_q, v_d;

    logic               run_s;
    logic               frame_end_s;
    logic               frame_first_s;
    logic               de_s;
    logic               hs_s;
    logic               vs_s;
    logic               pattern_active_s;
    logic [23:0]        bar_pix_s;
    logic               underflow_evt_s;

    logic [23:0]        pix_q, pix_d;
    logic               vd_q, vs_q, hs_q, fs_q;
    logic               underflow_q, underflow_d;

    assign run_s         = (state_q == ST_RUN);
    assign frame_end_s   = (h_q == H_LAST) && (v_q == V_LAST);
    assign frame_first_s = run_s && (h_q == CNT_ZERO) && (v_q == CNT_ZERO);

    assign de_s = run_s && (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hs_s = run_s && (h_q >= H_HS_BEG) && (h_q < H_HS_END);
    // vsync depends on the line count only, so it switches on h wrap.
    assign vs_s = run_s && (v_q >= V_VS_BEG) && (v_q < V_VS_END);

`ifdef DISPLAY_HDMI_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic pattern_q;

    // Bar colour for a horizontal position; the last bar takes any remainder.
    function automatic logic [23:0] bar_colour(input logic [CNT_W-1:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h >= CNT_W'(k * BAR_W)) begin
                idx = 3'(k);
            end
        end
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            3'd7:    bar_colour = 24'h000000;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    // The frame's first clock uses the live select so no pixel of a frame
    // ever mixes sources; afterwards the latched value holds.
    assign pattern_active_s = frame_first_s ? iPatternSel : pattern_q;
    assign bar_pix_s        = bar_colour(h_q);

    // Latch the pattern select once per frame.
    always_ff @(posedge iHdmiClk) begin
        if (!iRst_n) begin
            pattern_q <= 1'b0;
        end else if (frame_first_s) begin
            pattern_q <= iPatternSel;
        end else begin
            pattern_q <= pattern_q;
        end
    end
`else
    logic unused_pattern_sel_s;

    assign unused_pattern_sel_s = iPatternSel;
    assign pattern_active_s     = 1'b0;
    assign bar_pix_s            = 24'h000000;
`endif

    // Pop is suppressed during reset so a mid-frame reset cannot drain the FIFO.
    assign oPixRd          = iRst_n && de_s && !iPixEmpty && !pattern_active_s;
    assign underflow_evt_s = de_s && iPixEmpty && !pattern_active_s;

    // Raster FSM next state and counter advance.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                h_d = CNT_ZERO;
                v_d = CNT_ZERO;
                if (iEnable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = CNT_ZERO;
                    if (v_q == V_LAST) begin
                        v_d = CNT_ZERO;
                    end else begin
                        v_d = v_q + CNT_ONE;
                    end
                end else begin
                    h_d = h_q + CNT_ONE;
                    v_d = v_q;
                end
                // Stop only on the frame's final clock: no partial frames.
                if (frame_end_s && !iEnable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = CNT_ZERO;
                v_d     = CNT_ZERO;
            end
        endcase
    end

    // Pixel source select and sticky underflow next value.
    always_comb begin
        pix_d       = 24'h000000;
        underflow_d = underflow_q;
        if (!de_s) begin
            pix_d = 24'h000000;
        end else if (pattern_active_s) begin
            pix_d = bar_pix_s;
        end else if (!iPixEmpty) begin
            pix_d = iv24Pix;
        end else begin
            pix_d = 24'h000000;
        end

        if (underflow_evt_s) begin
            underflow_d = 1'b1;
        end else if (iClrStatus) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // FSM state and raster counters.
    always_ff @(posedge iHdmiClk) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            h_q     <= CNT_ZERO;
            v_q     <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Output pipeline stage: timing strobes, pixel and status.
    always_ff @(posedge iHdmiClk) begin
        if (!iRst_n) begin
            vd_q        <= 1'b0;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            fs_q        <= 1'b0;
            pix_q       <= 24'h000000;
            underflow_q <= 1'b0;
        end else begin
            vd_q        <= de_s;
            vs_q        <= vs_s;
            hs_q        <= hs_s;
            fs_q        <= frame_first_s && de_s;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    assign oRgbVd      = vd_q;
    assign oRgbVs      = vs_q;
    assign oRgbHs      = hs_q;
    assign oFrameStart = fs_q;
    assign ov8Red      = pix_q[23:16];
    assign ov8Green    = pix_q[15:8];
    assign ov8Blue     = pix_q[7:0];
    assign oUnderflow  = underflow_q;

endmodule
